// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
// Pipeline register and control-hazard sequencer between instruction fetch and
// decode. Captures the fetched word and its address one cycle later, inserts
// bubbles on clear, taken-jump redirect and while a fetched branch is waiting
// for execute to resolve it. A timeout guard forces a return to normal fetch
// if the branch is never resolved.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   if_inst    : instruction word from ROM for the current fetch address
//   if_pc      : current fetch address
//   if_br      : fetch-side indicator that if_inst is a control-flow op
//   hold_en    : freeze the stage
//   clear_en   : flush the stage to a bubble
//   jump_flag  : execute took a branch/jump, fetch redirected this cycle
//   br_done    : execute resolved the pending branch as not taken
//   id_inst    : instruction to decode (NOP_WORD during a bubble)
//   id_pc      : address of id_inst
//   id_valid   : id_inst is a real instruction
//   br_busy    : stage is waiting for branch resolution
//   br_err     : one-cycle pulse when the branch wait times out
//
// Optional feature (macro IF_ID_PERF_EN): saturating performance counters
//   perf_bubbles  : non-hold edges that loaded a bubble
//   perf_stalls   : edges with hold_en asserted
//   perf_timeouts : branch-wait timeouts
// -----------------------------------------------------------------------------
module if_id_stage #(
  parameter int                 ADDR_W     = 16,
  parameter int                 DATA_W     = 16,
  parameter logic [DATA_W-1:0]  NOP_WORD   = 16'h0001,
  parameter int                 BR_TIMEOUT = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_inst,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_br,
  input  logic              hold_en,
  input  logic              clear_en,
  input  logic              jump_flag,
  input  logic              br_done,
  output logic [DATA_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid,
  output logic              br_busy,
  output logic              br_err
`ifdef IF_ID_PERF_EN
  ,
  output logic [ADDR_W-1:0] perf_bubbles,
  output logic [ADDR_W-1:0] perf_stalls,
  output logic [7:0]        perf_timeouts
`endif
);

  // Code 2'b11 is unused and falls through to RUN behaviour.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_BR_WAIT = 2'b01,
    ST_FLUSH   = 2'b10
  } state_e;

  localparam logic [3:0] BR_TO = 4'(BR_TIMEOUT);

  state_e            state_q;
  logic [3:0]        br_cnt_q;
  logic [3:0]        br_cnt_d;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;
  logic              busy_q;
  logic              err_q;
  logic              timeout_evt;

  assign br_cnt_d = br_cnt_q + 4'd1;

  // The wait counter reaches its limit on an edge where nothing of higher
  // priority (reset, clear, hold, jump, resolution) claims the stage.
  assign timeout_evt = !rst && !clear_en && !hold_en && !jump_flag && !br_done &&
                       (state_q == ST_BR_WAIT) && (br_cnt_d == BR_TO);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and lives inside the edge.
  always_ff @(posedge clk) begin
    // br_err is a pulse: it drops on every edge other than the timeout edge.
    err_q <= 1'b0;
    if (rst) begin
      state_q  <= ST_RUN;
      br_cnt_q <= '0;
      inst_q   <= NOP_WORD;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (clear_en) begin
      state_q  <= ST_RUN;
      br_cnt_q <= '0;
      inst_q   <= NOP_WORD;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (hold_en) begin
      // Frozen: no register (including the wait counter) moves.
    end else if (jump_flag) begin
      // The word fetched this cycle is from the stale path; drop it and one more.
      state_q  <= ST_FLUSH;
      br_cnt_q <= '0;
      inst_q   <= NOP_WORD;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_BR_WAIT: begin
          // id_pc keeps the branch address while bubbles are presented.
          inst_q  <= NOP_WORD;
          valid_q <= 1'b0;
          if (br_done) begin
            state_q  <= ST_RUN;
            br_cnt_q <= '0;
            busy_q   <= 1'b0;
          end else if (timeout_evt) begin
            state_q  <= ST_RUN;
            br_cnt_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            br_cnt_q <= br_cnt_d;
          end
        end
        ST_FLUSH: begin
          state_q <= ST_RUN;
          inst_q  <= NOP_WORD;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= ST_RUN;
          inst_q  <= if_inst;
          pc_q    <= if_pc;
          // The all-zero halt word is passed through but never marked valid.
          valid_q <= |if_inst;
          if (if_br && (|if_inst)) begin
            state_q  <= ST_BR_WAIT;
            br_cnt_q <= '0;
            busy_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign id_inst  = inst_q;
  assign id_pc    = pc_q;
  assign id_valid = valid_q;
  assign br_busy  = busy_q;
  assign br_err   = err_q;

`ifdef IF_ID_PERF_EN
  logic              bubble_evt;
  logic [ADDR_W-1:0] perf_bub_q;
  logic [ADDR_W-1:0] perf_stall_q;
  logic [7:0]        perf_to_q;

  // A bubble is loaded by clear, or by a non-hold edge in jump/flush/wait.
  assign bubble_evt = !rst && (clear_en ||
                      (!hold_en && (jump_flag || (state_q == ST_BR_WAIT) ||
                                    (state_q == ST_FLUSH))));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bub_q   <= '0;
      perf_stall_q <= '0;
      perf_to_q    <= '0;
    end else begin
      if (bubble_evt && !(&perf_bub_q))   perf_bub_q   <= perf_bub_q + 1'b1;
      if (hold_en && !(&perf_stall_q))    perf_stall_q <= perf_stall_q + 1'b1;
      if (timeout_evt && !(&perf_to_q))   perf_to_q    <= perf_to_q + 1'b1;
    end
  end

  assign perf_bubbles  = perf_bub_q;
  assign perf_stalls   = perf_stall_q;
  assign perf_timeouts = perf_to_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
// Self-checking bench for if_id_stage. A behavioural model tracks what decode
// must see from the stage rules (pending-branch flag, cycles waited, bubbles
// still owed); a compare process checks every output against it on each
// falling edge. Directed sequences pin the model with literal expectations,
// then a randomized phase exercises all input combinations.
// -----------------------------------------------------------------------------
module tb_if_id_stage;

  localparam int          ADDR_W = 16;
  localparam int          DATA_W = 16;
  localparam logic [15:0] NOP    = 16'h0001;
  localparam int          TO     = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] if_inst = '0;
  logic [ADDR_W-1:0] if_pc = '0;
  logic              if_br = 1'b0;
  logic              hold_en = 1'b0;
  logic              clear_en = 1'b0;
  logic              jump_flag = 1'b0;
  logic              br_done = 1'b0;
  logic [DATA_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;
  logic              id_valid;
  logic              br_busy;
  logic              br_err;
`ifdef IF_ID_PERF_EN
  logic [ADDR_W-1:0] perf_bubbles;
  logic [ADDR_W-1:0] perf_stalls;
  logic [7:0]        perf_timeouts;
`endif

  if_id_stage #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(NOP), .BR_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .if_inst(if_inst), .if_pc(if_pc), .if_br(if_br),
    .hold_en(hold_en), .clear_en(clear_en), .jump_flag(jump_flag),
    .br_done(br_done), .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid),
    .br_busy(br_busy), .br_err(br_err)
`ifdef IF_ID_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls),
    .perf_timeouts(perf_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_inst = NOP;
  logic [15:0] m_pc = '0;
  bit          m_valid = 1'b0;
  bit          m_err = 1'b0;
  bit          waiting = 1'b0;   // a fetched branch awaits resolution
  int          waited = 0;       // wait cycles spent on it so far
  int          flush_left = 0;   // extra bubbles still owed after a jump
`ifdef IF_ID_PERF_EN
  int          m_bub = 0, m_stall = 0, m_to = 0;
`endif

  always @(posedge clk) begin
    bit bubble;
    bubble = 1'b0;
    if (rst) begin
      m_inst = NOP; m_pc = '0; m_valid = 0; m_err = 0;
      waiting = 0; waited = 0; flush_left = 0;
`ifdef IF_ID_PERF_EN
      m_bub = 0; m_stall = 0; m_to = 0;
`endif
    end else begin
      m_err = 0;
`ifdef IF_ID_PERF_EN
      if (hold_en) m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
`endif
      if (clear_en) begin
        bubble = 1; waiting = 0; waited = 0; flush_left = 0;
      end else if (hold_en) begin
        // nothing moves
      end else if (jump_flag) begin
        bubble = 1; waiting = 0; waited = 0; flush_left = 1;
      end else if (flush_left > 0) begin
        bubble = 1; flush_left--;
      end else if (waiting) begin
        bubble = 1;
        if (br_done) begin
          waiting = 0; waited = 0;
        end else begin
          waited++;
          if (waited == TO) begin
            m_err = 1; waiting = 0; waited = 0;
`ifdef IF_ID_PERF_EN
            m_to = (m_to < 255) ? m_to + 1 : m_to;
`endif
          end
        end
      end else begin
        m_inst  = if_inst;
        m_pc    = if_pc;
        m_valid = (if_inst != 0);
        if (if_br && if_inst != 0) begin waiting = 1; waited = 0; end
      end
      if (bubble) begin
        m_inst = NOP; m_valid = 0;
`ifdef IF_ID_PERF_EN
        m_bub = (m_bub < 65535) ? m_bub + 1 : m_bub;
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("id_inst",  32'(id_inst),  32'(m_inst));
      check("id_pc",    32'(id_pc),    32'(m_pc));
      check("id_valid", 32'(id_valid), 32'(m_valid));
      check("br_busy",  32'(br_busy),  32'(waiting));
      check("br_err",   32'(br_err),   32'(m_err));
`ifdef IF_ID_PERF_EN
      check("perf_bubbles",  32'(perf_bubbles),  32'(m_bub));
      check("perf_stalls",   32'(perf_stalls),   32'(m_stall));
      check("perf_timeouts", 32'(perf_timeouts), 32'(m_to));
`endif
    end
  end

  // One clock: apply inputs, take the rising edge, return 2 time units later.
  task automatic cyc(input logic r, input logic [15:0] inst, input logic [15:0] pc,
                     input logic br, input logic hld, input logic clr,
                     input logic jmp, input logic done);
    rst = r; if_inst = inst; if_pc = pc; if_br = br;
    hold_en = hld; clear_en = clr; jump_flag = jmp; br_done = done;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [15:0] inst, input logic [15:0] pc);
    cyc(0, inst, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] inst,
                            input logic [15:0] pc, input logic v,
                            input logic busy, input logic err);
    check({tag, ".inst"},  32'(id_inst),  32'(inst));
    check({tag, ".pc"},    32'(id_pc),    32'(pc));
    check({tag, ".valid"}, 32'(id_valid), 32'(v));
    check({tag, ".busy"},  32'(br_busy),  32'(busy));
    check({tag, ".err"},   32'(br_err),   32'(err));
  endtask

  initial begin
    // Reset for two cycles, then a plain capture.
    cyc(1, 16'h1234, 16'd5, 0, 0, 0, 0, 0);
    cmp_en = 1'b1;
    cyc(1, 16'h1234, 16'd5, 0, 0, 0, 0, 0);
    expect_out("reset", NOP, 16'd0, 0, 0, 0);
    idle(16'h1234, 16'd5);
    expect_out("rel", 16'h1234, 16'd5, 1, 0, 0);

    // Branch not taken: two unresolved cycles, then br_done.
    cyc(0, 16'hB003, 16'd3, 1, 0, 0, 0, 0);
    expect_out("br_cap", 16'hB003, 16'd3, 1, 1, 0);
    idle(16'hAAAA, 16'd4);
    expect_out("br_w1", NOP, 16'd3, 0, 1, 0);
    idle(16'hAAAA, 16'd4);
    expect_out("br_w2", NOP, 16'd3, 0, 1, 0);
    cyc(0, 16'hAAAA, 16'd4, 0, 0, 0, 0, 1);
    expect_out("br_done", NOP, 16'd3, 0, 0, 0);
    idle(16'h0444, 16'd4);
    expect_out("br_next", 16'h0444, 16'd4, 1, 0, 0);

    // Taken jump while waiting, with br_done at the same time.
    cyc(0, 16'h2000, 16'd6, 1, 0, 0, 0, 0);
    expect_out("jmp_cap", 16'h2000, 16'd6, 1, 1, 0);
    cyc(0, 16'hDEAD, 16'd7, 0, 0, 0, 1, 1);
    expect_out("jmp_b1", NOP, 16'd6, 0, 0, 0);
    idle(16'h5555, 16'd20);
    expect_out("jmp_b2", NOP, 16'd6, 0, 0, 0);
    idle(16'h5555, 16'd20);
    expect_out("jmp_tgt", 16'h5555, 16'd20, 1, 0, 0);

    // Timeout: seven unresolved wait edges.
    cyc(0, 16'h3000, 16'd30, 1, 0, 0, 0, 0);
    for (int i = 1; i < TO; i++) begin
      idle(16'h0777, 16'd31);
      expect_out("to_wait", NOP, 16'd30, 0, 1, 0);
    end
    idle(16'h0777, 16'd31);
    expect_out("to_err", NOP, 16'd30, 0, 0, 1);
    idle(16'h0777, 16'd31);
    expect_out("to_after", 16'h0777, 16'd31, 1, 0, 0);

    // Hold at counter 2 freezes the count: timeout lands 5 edges after release.
    cyc(0, 16'h4000, 16'd40, 1, 0, 0, 0, 0);
    idle(16'h0111, 16'd41);
    idle(16'h0111, 16'd41);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0111, 16'd41, 0, 1, 0, 0, 0);
      expect_out("hold", NOP, 16'd40, 0, 1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      idle(16'h0111, 16'd41);
      expect_out("hold_post", NOP, 16'd40, 0, 1, 0);
    end
    idle(16'h0111, 16'd41);
    expect_out("hold_to", NOP, 16'd40, 0, 0, 1);

    // Clear beats hold.
    cyc(0, 16'h4100, 16'd42, 1, 0, 0, 0, 0);
    idle(16'h0222, 16'd43);
    cyc(0, 16'h0222, 16'd43, 0, 1, 1, 0, 0);
    expect_out("clr_hold", NOP, 16'd42, 0, 0, 0);
    idle(16'h0222, 16'd43);
    expect_out("clr_next", 16'h0222, 16'd43, 1, 0, 0);

    // Halt word with if_br set: captured invalid, no branch wait.
    cyc(0, 16'h0000, 16'd50, 1, 0, 0, 0, 0);
    expect_out("halt", 16'h0000, 16'd50, 0, 0, 0);
    idle(16'h0888, 16'd51);
    expect_out("halt_next", 16'h0888, 16'd51, 1, 0, 0);

    // br_done in RUN is ignored; jump_flag in RUN still flushes twice.
    cyc(0, 16'h0999, 16'd52, 0, 0, 0, 0, 1);
    expect_out("done_run", 16'h0999, 16'd52, 1, 0, 0);
    cyc(0, 16'h0AAA, 16'd53, 0, 0, 0, 1, 0);
    expect_out("jmp_run", NOP, 16'd52, 0, 0, 0);
    idle(16'h0BBB, 16'd60);
    expect_out("jmp_run2", NOP, 16'd52, 0, 0, 0);

    // Reset in the middle of a branch wait: no error pulse.
    cyc(0, 16'h6000, 16'd61, 1, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) idle(16'h0CCC, 16'd62);
    cyc(1, 16'h0CCC, 16'd62, 0, 0, 0, 0, 0);
    expect_out("rst_mid", NOP, 16'd0, 0, 0, 0);
    idle(16'h0CCC, 16'd62);
    expect_out("rst_mid2", 16'h0CCC, 16'd62, 1, 0, 0);

    // Randomized phase; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] w;
      w = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      cyc($urandom_range(0, 99) < 2,
          w, 16'($urandom),
          $urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 10);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
